// File: rtl/mwc_pkg.sv
// Shared types for the data-memory write checker: verdict encoding and the
// expected-write table entry.
package mwc_pkg;

  // Widest supported XLEN; table fields are stored zero-extended to this width.
  localparam int MWC_XLEN_MAX = 64;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4
  } chk_status_e;

  typedef struct packed {
    logic [MWC_XLEN_MAX-1:0] addr;
    logic [MWC_XLEN_MAX-1:0] data;
    logic [MWC_XLEN_MAX-1:0] pc;
    logic                    pc_en;
    logic                    valid;
  } exp_entry_t;

  function automatic logic [4:0] count_ones16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) begin
      c = c + {4'b0000, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/mwc_match_unit.sv
// Combinational store comparator: per-entry hit / data-equal vectors and
// lowest-index selection of the open entry, first good hit and first hit.
module mwc_match_unit
  import mwc_pkg::*;
#(
  parameter int NUM_EXP = 4,
  parameter int IDX_W   = 2
) (
  input  exp_entry_t [NUM_EXP-1:0]  entries,
  input  logic [NUM_EXP-1:0]        matched,
  input  logic [MWC_XLEN_MAX-1:0]   addr,
  input  logic [MWC_XLEN_MAX-1:0]   data,
  input  logic [MWC_XLEN_MAX-1:0]   pc,
  output logic [IDX_W-1:0]          ptr_idx,
  output logic                      ptr_found,
  output logic                      ptr_hit,
  output logic                      ptr_eq,
  output logic [IDX_W-1:0]          good_idx,
  output logic                      good_found,
  output logic [IDX_W-1:0]          hit_idx,
  output logic                      hit_found
);

  logic [NUM_EXP-1:0] open_vec;
  logic [NUM_EXP-1:0] hit_vec;
  logic [NUM_EXP-1:0] eq_vec;

  for (genvar gi = 0; gi < NUM_EXP; gi++) begin : g_cmp
    assign open_vec[gi] = entries[gi].valid & ~matched[gi];
    assign hit_vec[gi]  = open_vec[gi] & (entries[gi].addr == addr) &
                          (~entries[gi].pc_en | (entries[gi].pc == pc));
    assign eq_vec[gi]   = (entries[gi].data == data);
  end

  // Scanning high to low leaves the lowest qualifying index in each result.
  always_comb begin
    ptr_idx    = '0;
    ptr_found  = 1'b0;
    ptr_hit    = 1'b0;
    ptr_eq     = 1'b0;
    good_idx   = '0;
    good_found = 1'b0;
    hit_idx    = '0;
    hit_found  = 1'b0;
    for (int i = NUM_EXP - 1; i >= 0; i--) begin
      if (open_vec[i]) begin
        ptr_idx   = IDX_W'(i);
        ptr_found = 1'b1;
        ptr_hit   = hit_vec[i];
        ptr_eq    = eq_vec[i];
      end
      if (hit_vec[i] && eq_vec[i]) begin
        good_idx   = IDX_W'(i);
        good_found = 1'b1;
      end
      if (hit_vec[i]) begin
        hit_idx   = IDX_W'(i);
        hit_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_write_checker.sv
// Snoops the data-memory write port and checks stores against a table of
// expected writes, reporting PASS / FAIL / TIMEOUT on a registered status bus.
module mem_write_checker
  import mwc_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int NUM_EXP        = 4,
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int ORDERED        = 1,
  parameter int IDX_W          = (NUM_EXP > 1) ? $clog2(NUM_EXP) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mon_we,
  input  logic [XLEN-1:0]  mon_addr,
  input  logic [XLEN-1:0]  mon_data,
  input  logic [XLEN-1:0]  mon_pc,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [XLEN-1:0]  cfg_addr,
  input  logic [XLEN-1:0]  cfg_data,
  input  logic [XLEN-1:0]  cfg_pc,
  input  logic             cfg_pc_en,
  input  logic             cfg_valid,
  input  logic             start,
  input  logic             clear,
  output logic [2:0]       status,
  output logic             done,
  output logic [IDX_W:0]   match_cnt,
  output logic [IDX_W-1:0] fail_idx,
  output logic [XLEN-1:0]  fail_addr,
  output logic [XLEN-1:0]  fail_data
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  exp_entry_t [NUM_EXP-1:0] entries_reg;
  logic [NUM_EXP-1:0]       matched_reg;
  logic [NUM_EXP-1:0]       valid_vec;
  logic [NUM_EXP-1:0]       match_mask;
  chk_status_e              state_reg;
  logic                     done_reg;
  logic [IDX_W:0]           match_cnt_reg;
  logic [IDX_W:0]           match_cnt_next;
  logic [CNT_W-1:0]         cnt_reg;
  logic [IDX_W-1:0]         fail_idx_reg;
  logic [XLEN-1:0]          fail_addr_reg;
  logic [XLEN-1:0]          fail_data_reg;

  logic                     armed;
  logic [IDX_W-1:0]         ptr_idx, good_idx, hit_idx;
  logic                     ptr_found, ptr_hit, ptr_eq, good_found, hit_found;
  logic                     do_match, do_fail;
  logic [IDX_W-1:0]         match_idx, fail_idx_next;
  logic [4:0]               valid_cnt;
  logic                     all_matched;
  logic                     timeout_hit;

  assign armed = (state_reg == ST_ARMED);

  // Table writes are blocked while armed; indices beyond NUM_EXP match no entry.
  for (genvar gi = 0; gi < NUM_EXP; gi++) begin : g_entry
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        entries_reg[gi] <= '0;
      end else if (cfg_we && !armed && (cfg_idx == IDX_W'(gi))) begin
        entries_reg[gi] <= '{addr:  MWC_XLEN_MAX'(cfg_addr),
                             data:  MWC_XLEN_MAX'(cfg_data),
                             pc:    MWC_XLEN_MAX'(cfg_pc),
                             pc_en: cfg_pc_en,
                             valid: cfg_valid};
      end
    end
    assign valid_vec[gi]  = entries_reg[gi].valid;
    assign match_mask[gi] = do_match && (match_idx == IDX_W'(gi));
  end

  mwc_match_unit #(
    .NUM_EXP (NUM_EXP),
    .IDX_W   (IDX_W)
  ) u_match (
    .entries    (entries_reg),
    .matched    (matched_reg),
    .addr       (MWC_XLEN_MAX'(mon_addr)),
    .data       (MWC_XLEN_MAX'(mon_data)),
    .pc         (MWC_XLEN_MAX'(mon_pc)),
    .ptr_idx    (ptr_idx),
    .ptr_found  (ptr_found),
    .ptr_hit    (ptr_hit),
    .ptr_eq     (ptr_eq),
    .good_idx   (good_idx),
    .good_found (good_found),
    .hit_idx    (hit_idx),
    .hit_found  (hit_found)
  );

  always_comb begin
    do_match      = 1'b0;
    do_fail       = 1'b0;
    match_idx     = ptr_idx;
    fail_idx_next = ptr_idx;
    if (armed && mon_we) begin
      if (ORDERED != 0) begin
        if (ptr_found && ptr_hit) begin
          do_match = ptr_eq;
          do_fail  = !ptr_eq;
        end
      end else begin
        if (good_found) begin
          do_match  = 1'b1;
          match_idx = good_idx;
        end else if (hit_found) begin
          do_fail       = 1'b1;
          fail_idx_next = hit_idx;
        end
      end
    end
  end

  assign valid_cnt      = count_ones16(16'(valid_vec));
  assign match_cnt_next = match_cnt_reg + (IDX_W + 1)'(1);
  assign all_matched    = (5'(match_cnt_next) == valid_cnt);
  assign timeout_hit    = (TIMEOUT_CYCLES != 0) &&
                          (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

  // Verdict priority within one edge: FAIL, then PASS, then TIMEOUT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      done_reg      <= 1'b0;
      matched_reg   <= '0;
      match_cnt_reg <= '0;
      cnt_reg       <= '0;
      fail_idx_reg  <= '0;
      fail_addr_reg <= '0;
      fail_data_reg <= '0;
    end else if (clear || (start && !armed)) begin
      matched_reg   <= '0;
      match_cnt_reg <= '0;
      cnt_reg       <= '0;
      fail_idx_reg  <= '0;
      fail_addr_reg <= '0;
      fail_data_reg <= '0;
      if (clear) begin
        state_reg <= ST_IDLE;
        done_reg  <= 1'b0;
      end else if (valid_vec == '0) begin
        state_reg <= ST_PASS;
        done_reg  <= 1'b1;
      end else begin
        state_reg <= ST_ARMED;
        done_reg  <= 1'b0;
      end
    end else if (armed) begin
      if (cnt_reg != '1) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
      if (do_match) begin
        matched_reg   <= matched_reg | match_mask;
        match_cnt_reg <= match_cnt_next;
      end
      if (do_fail) begin
        state_reg     <= ST_FAIL;
        done_reg      <= 1'b1;
        fail_idx_reg  <= fail_idx_next;
        fail_addr_reg <= mon_addr;
        fail_data_reg <= mon_data;
      end else if (do_match && all_matched) begin
        state_reg <= ST_PASS;
        done_reg  <= 1'b1;
      end else if (timeout_hit) begin
        state_reg <= ST_TIMEOUT;
        done_reg  <= 1'b1;
      end
    end
  end

  assign status    = state_reg;
  assign done      = done_reg;
  assign match_cnt = match_cnt_reg;
  assign fail_idx  = fail_idx_reg;
  assign fail_addr = fail_addr_reg;
  assign fail_data = fail_data_reg;

endmodule

// File: tb/tb_mem_write_checker.sv
// Directed bench: an ordered and an unordered checker share one stimulus
// stream; outputs are sampled 1 time unit after each rising edge.
module tb_mem_write_checker;

  localparam int XLEN  = 32;
  localparam int NEXP  = 4;
  localparam int IW    = 2;

  localparam logic [2:0] S_IDLE = 3'd0, S_ARMED = 3'd1, S_PASS = 3'd2,
                         S_FAIL = 3'd3, S_TMO = 3'd4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            mon_we = 1'b0;
  logic [XLEN-1:0] mon_addr = '0, mon_data = '0, mon_pc = '0;
  logic            cfg_we = 1'b0;
  logic [IW-1:0]   cfg_idx = '0;
  logic [XLEN-1:0] cfg_addr = '0, cfg_data = '0, cfg_pc = '0;
  logic            cfg_pc_en = 1'b0, cfg_valid = 1'b0;
  logic            start = 1'b0, clear = 1'b0;

  logic [2:0]      o_status, u_status;
  logic            o_done, u_done;
  logic [IW:0]     o_mcnt, u_mcnt;
  logic [IW-1:0]   o_fidx, u_fidx;
  logic [XLEN-1:0] o_faddr, u_faddr, o_fdata, u_fdata;

  int tests_run = 0;
  int fail_cnt  = 0;

  always #5 clk = ~clk;

  mem_write_checker #(.XLEN(XLEN), .NUM_EXP(NEXP), .TIMEOUT_CYCLES(20), .ORDERED(1)) u_ord (
    .clk(clk), .reset(reset), .mon_we(mon_we), .mon_addr(mon_addr), .mon_data(mon_data),
    .mon_pc(mon_pc), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_pc(cfg_pc), .cfg_pc_en(cfg_pc_en), .cfg_valid(cfg_valid),
    .start(start), .clear(clear), .status(o_status), .done(o_done), .match_cnt(o_mcnt),
    .fail_idx(o_fidx), .fail_addr(o_faddr), .fail_data(o_fdata)
  );

  mem_write_checker #(.XLEN(XLEN), .NUM_EXP(NEXP), .TIMEOUT_CYCLES(20), .ORDERED(0)) u_uno (
    .clk(clk), .reset(reset), .mon_we(mon_we), .mon_addr(mon_addr), .mon_data(mon_data),
    .mon_pc(mon_pc), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_pc(cfg_pc), .cfg_pc_en(cfg_pc_en), .cfg_valid(cfg_valid),
    .start(start), .clear(clear), .status(u_status), .done(u_done), .match_cnt(u_mcnt),
    .fail_idx(u_fidx), .fail_addr(u_faddr), .fail_data(u_fdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic cfg(input logic [IW-1:0] idx, input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] pc, input logic pc_en, input logic vld);
    cfg_we = 1'b1; cfg_idx = idx; cfg_addr = a; cfg_data = d;
    cfg_pc = pc; cfg_pc_en = pc_en; cfg_valid = vld;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [31:0] pc);
    mon_we = 1'b1; mon_addr = a; mon_data = d; mon_pc = pc;
    tick();
    mon_we = 1'b0;
    $display("[TB] store addr=0x%0h data=0x%0h pc=0x%0h -> ord=%0d uno=%0d",
             a, d, pc, o_status, u_status);
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  initial begin
    // Asynchronous reset assertion
    #2 reset = 1'b0;
    #1;
    check("rst_status", o_status, S_IDLE);
    check("rst_done", o_done, 0);
    check("rst_mcnt", o_mcnt, 0);
    check("rst_faddr", o_faddr, 0);
    idle(2);
    reset = 1'b1;
    tick();

    // Single entry 0x64/0x19, matching store on the 10th edge after arming
    cfg(0, 32'h64, 32'h19, 32'h0, 1'b0, 1'b1);
    pulse_start();
    check("t1_armed", o_status, S_ARMED);
    idle(9);
    store(32'h64, 32'h19, 32'h0);
    check("t1_pass", o_status, S_PASS);
    check("t1_mcnt", o_mcnt, 1);
    check("t1_done", o_done, 1);
    check("t1_uno_pass", u_status, S_PASS);

    // Wrong data -> FAIL with capture; sticky afterwards
    pulse_start();
    check("t2_armed", o_status, S_ARMED);
    check("t2_mcnt_clr", o_mcnt, 0);
    store(32'h64, 32'h1A, 32'h0);
    check("t2_fail", o_status, S_FAIL);
    check("t2_fidx", o_fidx, 0);
    check("t2_faddr", o_faddr, 32'h64);
    check("t2_fdata", o_fdata, 32'h1A);
    check("t2_uno_fail", u_status, S_FAIL);
    store(32'h64, 32'h19, 32'h0);
    check("t2_sticky", o_status, S_FAIL);
    check("t2_sticky_mcnt", o_mcnt, 0);

    // Ordered vs unordered matching
    pulse_clear();
    check("t3_idle", o_status, S_IDLE);
    check("t3_fdata_clr", o_fdata, 0);
    cfg(0, 32'h10, 32'h1, 32'h0, 1'b0, 1'b1);
    cfg(1, 32'h14, 32'h2, 32'h0, 1'b0, 1'b1);
    pulse_start();
    store(32'h14, 32'h2, 32'h0);
    check("t3_ord_skip", o_mcnt, 0);
    check("t3_ord_armed", o_status, S_ARMED);
    check("t3_uno_mcnt1", u_mcnt, 1);
    store(32'h10, 32'h1, 32'h0);
    check("t3_ord_mcnt1", o_mcnt, 1);
    check("t3_ord_armed2", o_status, S_ARMED);
    check("t3_uno_pass", u_status, S_PASS);
    check("t3_uno_mcnt2", u_mcnt, 2);
    store(32'h14, 32'h2, 32'h0);
    check("t3_ord_pass", o_status, S_PASS);
    check("t3_ord_mcnt2", o_mcnt, 2);

    // Timeout after 20 armed edges; config writes while armed are dropped
    pulse_clear();
    cfg(1, 32'h14, 32'h2, 32'h0, 1'b0, 1'b0);
    pulse_start();
    idle(5);
    cfg(0, 32'h99, 32'h9, 32'h0, 1'b0, 1'b1);
    idle(13);
    check("t4_armed19", o_status, S_ARMED);
    idle(1);
    check("t4_timeout", o_status, S_TMO);
    check("t4_done", o_done, 1);
    check("t4_uno_timeout", u_status, S_TMO);
    pulse_start();
    idle(19);
    check("t4b_armed19", o_status, S_ARMED);
    store(32'h10, 32'h1, 32'h0);
    check("t4b_pass_on_edge20", o_status, S_PASS);
    check("t4b_uno_pass", u_status, S_PASS);

    // PC-qualified entry
    pulse_clear();
    cfg(0, 32'h64, 32'h19, 32'h4C, 1'b1, 1'b1);
    pulse_start();
    store(32'h64, 32'h19, 32'h48);
    check("t5_pc_ignored", o_status, S_ARMED);
    check("t5_pc_mcnt", o_mcnt, 0);
    store(32'h64, 32'h19, 32'h4C);
    check("t5_pass", o_status, S_PASS);

    // Async reset mid-ARMED, then empty table, then clear beats start
    pulse_start();
    idle(2);
    check("t6_armed", o_status, S_ARMED);
    #2 reset = 1'b0;
    #1;
    check("t6_async_idle", o_status, S_IDLE);
    check("t6_async_done", o_done, 0);
    #1 reset = 1'b1;
    tick();
    pulse_start();
    check("t6_empty_pass", o_status, S_PASS);
    check("t6_empty_done", o_done, 1);
    start = 1'b1; clear = 1'b1;
    tick();
    start = 1'b0; clear = 1'b0;
    check("t6_clear_wins", o_status, S_IDLE);
    check("t6_clear_done", o_done, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule

// File: doc/mem_write_checker.md
Name: mem_write_checker

Overview:
- Synthesizable self-check block that snoops the CPU data-memory write port (we, DataAdr, WriteData, PC).
- Compares observed stores against a table of up to NUM_EXP expected (address, data, optional PC) entries, in ordered or unordered mode, with a cycle timeout.
- Reports a pass / fail / timeout verdict on a status bus.
- Sits beside the top-level core, in simulation or on-board; drives LED or debug outputs for both single-cycle and pipelined builds.

Parameters:
- XLEN, 32, width of address, data and PC.
- NUM_EXP, 4, number of expected-write table entries (1..16).
- TIMEOUT_CYCLES, 5000, cycles armed before TIMEOUT; 0 disables timeout.
- ORDERED, 1, 1 = entries must match in index order; 0 = any order.
- IDX_W, $clog2(NUM_EXP) (min 1), table index width.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- mon_we  in  1  dmem write enable
- mon_addr  in  XLEN  dmem write address
- mon_data  in  XLEN  dmem write data
- mon_pc  in  XLEN  PC associated with the store
- cfg_we  in  1  write one table entry
- cfg_idx  in  IDX_W  entry index
- cfg_addr  in  XLEN  expected address
- cfg_data  in  XLEN  expected data
- cfg_pc  in  XLEN  expected PC
- cfg_pc_en  in  1  entry also requires PC match
- cfg_valid  in  1  entry participates in the check
- start  in  1  arm the checker
- clear  in  1  return to IDLE
- status  out  3  0 = IDLE, 1 = ARMED, 2 = PASS, 3 = FAIL, 4 = TIMEOUT
- done  out  1  status is PASS, FAIL or TIMEOUT
- match_cnt  out  IDX_W+1  entries matched so far
- fail_idx  out  IDX_W  entry that mismatched
- fail_addr  out  XLEN  captured mismatching address
- fail_data  out  XLEN  captured mismatching data

Behaviour:
- Reset (reset = 0, async):
  - status = IDLE, done = 0, match_cnt = 0, fail_* = 0.
  - All table valid bits cleared, matched bits cleared, timeout counter = 0.
- Config:
  - cfg_we is accepted in IDLE, PASS, FAIL and TIMEOUT; the entry updates on the next clk edge.
  - cfg_we is ignored in ARMED.
  - Out-of-range cfg_idx is ignored.
- start, when not ARMED:
  - Clears matched bits, match_cnt, counter and fail_*.
  - Next state is ARMED; if no entry is valid, next state is PASS directly.
  - start while ARMED is ignored.
- clear: from any state, next state is IDLE; matched bits, match_cnt, counter and fail_* are cleared; table contents are kept. clear beats start.
- ARMED, sampled each clk edge when mon_we = 1:
  - Hit: addr equal, and PC equal if pc_en.
  - ORDERED = 1: hit is tested only against the entry at pointer ptr (lowest unmatched valid index).
    - Hit with data equal: mark matched, match_cnt += 1.
    - Hit with data unequal: FAIL; capture fail_idx = ptr, fail_addr, fail_data.
    - Non-hit writes are ignored.
  - ORDERED = 0: test all unmatched valid entries.
    - Lowest-index hit with data equal: mark matched.
    - Hits but none with equal data: FAIL, capture the lowest hit index.
    - Writes to already-matched addresses are ignored.
- Verdict:
  - When match_cnt reaches the valid-entry count, next state is PASS; the single-cycle latency is the edge after the final store.
  - Counter increments each ARMED cycle. When TIMEOUT_CYCLES ≠ 0 and the counter reaches TIMEOUT_CYCLES - 1 without a verdict, next state is TIMEOUT.
- Priority on the same edge: FAIL > PASS > TIMEOUT. A final match on the timeout cycle yields PASS.
- PASS, FAIL and TIMEOUT are sticky until start, clear or reset. Monitor inputs are ignored there.
- The counter saturates and does not wrap; width is $clog2(TIMEOUT_CYCLES+1).
- done = (status ≥ 2), registered together with status.

Decomposition:
- Shared package mwc_pkg:
  - enum chk_status_e {ST_IDLE, ST_ARMED, ST_PASS, ST_FAIL, ST_TIMEOUT}, 3-bit encoding.
  - Struct exp_entry_t {addr, data, pc, pc_en, valid}.
- One sub-module: mwc_match_unit. Combinational per-entry hit/data-equal vector plus a lowest-index priority encoder, instantiated once. The FSM, table and counter stay in the top.

Test Plan:
1. NUM_EXP = 1, entry {addr = 0x64, data = 0x19}, start, then drive store 0x64/0x19 at cycle 10 -> status = PASS at cycle 11, match_cnt = 1, done = 1.
2. Same entry, drive store 0x64/0x1A -> FAIL, fail_idx = 0, fail_addr = 0x64, fail_data = 0x1A. A later correct store leaves FAIL unchanged.
3. ORDERED = 1, entries 0x10/1 and 0x14/2, drive 0x14/2 then 0x10/1 then 0x14/2 -> the first store is ignored (not a hit at ptr) and the final state is PASS, match_cnt = 2. With ORDERED = 0, PASS occurs after the second store.
4. TIMEOUT_CYCLES = 20, no stores -> TIMEOUT exactly 20 cycles after arming. The matching store on cycle 20 instead yields PASS.
5. Entry with pc_en = 1, pc = 0x4C; store 0x64/0x19 at PC 0x48 -> ignored; same store at PC 0x4C -> PASS.
6. reset asserted low mid-ARMED (async, between edges) -> status = IDLE immediately and the table is invalid. clear + start on the same cycle -> IDLE.
